keccak_load_stage: RTL and testbench
====================================

# keccak_load_stage

Parametrised input stage for the Keccak core. It accepts a header and then a byte-aligned message over a valid/ready word bus, and applies the FIPS 202 domain suffix and pad10*1 padding. It assembles rate-sized blocks for any of six SHA-3/SHAKE modes and hands each block to the absorb stage through a valid/ready block handshake.

## Interface
- W, 64: bus word width in bits; legal values 32 and 64.
- RATE_MAX, 1344: width of the block output (SHAKE128 rate).
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- data_i  in  W  header/message word; message byte 0 is data_i[W-1:W-8].
- valid_i  in  1  data_i valid.
- ready_o  out  1  stage accepts data_i this cycle.
- block_o  out  RATE_MAX  assembled block, little-endian lanes; bits at and above the mode's rate are zero.
- block_valid_o  out  1  block_o, last_block_o, mode_o and output_size_o are valid.
- block_ready_i  in  1  absorb stage takes the block.
- last_block_o  out  1  current block carries the final pad bit.
- mode_o  out  3  latched mode.
- output_size_o  out  32  latched output length in bits, zero-extended.
- busy_o  out  1  state != IDLE.

## Operation
- Header: 64 bits, sent as 64/W words, most significant word first.
  - [63:61] mode: 0 SHA3-224 (rate 1152), 1 SHA3-256 (1088), 2 SHA3-384 (832), 3 SHA3-512 (576), 4 SHAKE128 (1344), 5 SHAKE256 (1088). Codes 6 and 7 are treated as 4.
  - [59:32] output size in bits.
  - [31:0] message size in bits. Bits [2:0] are ignored, so bytes_left = size>>3.
- FSM states:
  - IDLE: ready_o=1. The first accepted word goes to HEADER if W=32; if W=64 the header is complete and the next state is ABSORB, or PAD when bytes_left=0.
  - HEADER: W=32 only; the second header word is latched. Exit to ABSORB, or to PAD when bytes_left=0.
  - ABSORB: ready_o=1. Each accepted word is byte-swapped and written to block word index wc. bytes_left decrements by min(W/8, bytes_left) and wc increments.
  - PAD: ready_o=0. Pad words are generated internally, one per cycle.
  - HOLD: ready_o=0, block_valid_o=1. On block_ready_i, go to IDLE if last_block_o was set; otherwise go to ABSORB if bytes_left>0, else to PAD. Leaving HOLD clears the block register and wc.
- Final partial word (bytes_left < W/8): valid bytes are kept and the remaining input bytes are masked. The next byte becomes the suffix (0x06 for SHA3, 0x1F for SHAKE); the rest are zero. The suffix-done flag is set.
- Exact word end (bytes_left reaches 0 on a full word): the next state is PAD. The suffix goes in the first pad byte.
- Block word index wc == rate/W-1 marks the last word of the block:
  - If the suffix is placed in or before this word, 0x80 is ORed into its final byte and last_block_o is set. A suffix and pad bit in the same byte give 0x86 or 0x9F.
  - Filling the block moves the state to HOLD.
- A message ending on a block boundary produces an extra, fully padded block.
- PAD words are all zero except for the suffix and the 0x80 rules above.

## Timing
- Reset values: ready_o=0 while rst is asserted, then 1 in IDLE. block_o, block_valid_o, last_block_o, mode_o, output_size_o and busy_o are all 0.
- ready_o and block_valid_o are decoded from registered state only, with no combinational path from the inputs.
- A transfer happens on valid_i&&ready_o at the clock edge.
- block_valid_o rises the cycle after the block's last word is written and holds until block_ready_i. block_o is stable throughout.
- Throughput is one word per cycle in ABSORB and PAD. A block_ready_i in HOLD gives a one-cycle bubble before the next word is accepted.
- valid_i low in ABSORB stalls the stage with no state change.
- Asserting rst mid-message aborts the message. All state and counters clear immediately.
- Counters: bytes_left is 29 bits; wc is $clog2(RATE_MAX/32) bits.

## Structure
- keccak_pkg holds:
  - mode_t enum and the rate_bits(mode) function;
  - SUFFIX_SHA3=8'h06, SUFFIX_SHAKE=8'h1F and PAD_END=8'h80;
  - the existing EndianSwitcher.
- Sub-module keccak_word_padder: combinational. Inputs are the word, valid byte count, suffix, suffix_pending and last_in_block. Outputs are the padded word and suffix_placed.
- The block register is written per word through a wc-indexed write enable, not a shift chain, so variable rate is handled without realignment.

## Test plan
- W=64, mode 4, size 0: one block, block_o byte 0=0x1F, byte 167=0x80, last_block_o=1, all other bytes 0.
- W=64, mode 1, size 1080 bits (135 bytes): 17th word holds the final message byte and byte 135=0x86. The block is last, with zero extra blocks.
- W=64, mode 3, size 576 bits (one full rate): two blocks. The second is 0x06 at byte 0 and 0x80 at byte 71; only the second has last_block_o.
- W=32, mode 5, size 24 bits: two header words, then one data word 0xAABBCCDD. block_o bytes 0..3 are AA BB CC 1F, byte 135=0x80. Mode and size latch correctly.
- Backpressure: block_ready_i held low for 10 cycles in HOLD. ready_o=0, block_o stable, and no words are lost when valid_i is toggled randomly.
- rst pulsed low in ABSORB mid-block: all outputs are 0 next cycle, and a following fresh message is produced correctly.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared types, constants and helpers for the Keccak input path.
// Mode codes, per-mode rate, domain suffixes and byte-order utilities.
package keccak_pkg;

    typedef enum logic [2:0] {
        Sha3_224 = 3'd0,
        Sha3_256 = 3'd1,
        Sha3_384 = 3'd2,
        Sha3_512 = 3'd3,
        Shake128 = 3'd4,
        Shake256 = 3'd5
    } mode_t;

    localparam logic [7:0] SUFFIX_SHA3  = 8'h06;
    localparam logic [7:0] SUFFIX_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_END      = 8'h80;

    // Unassigned codes fall back to SHAKE128, the widest rate.
    function automatic mode_t mode_decode(input logic [2:0] code);
        return (code > 3'd5) ? Shake128 : mode_t'(code);
    endfunction

    function automatic int unsigned rate_bits(input mode_t mode);
        case (mode)
            Sha3_224: return 1152;
            Sha3_256: return 1088;
            Sha3_384: return 832;
            Sha3_512: return 576;
            Shake256: return 1088;
            default:  return 1344;
        endcase
    endfunction

    function automatic logic is_shake(input mode_t mode);
        return (mode == Shake128) || (mode == Shake256);
    endfunction

    function automatic logic [63:0] EndianSwitcher(input logic [63:0] w);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = w[8*(7-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/keccak_word_padder.sv
// Applies byte masking, the domain suffix and the final pad bit to one
// little-endian bus word.
module keccak_word_padder
    import keccak_pkg::*;
#(
    parameter int unsigned W  = 64,
    parameter int unsigned CW = $clog2(W/8 + 1)
) (
    input  logic [W-1:0]  word_i,
    input  logic [CW-1:0] count_i,
    input  logic [7:0]    suffix_i,
    input  logic          suffix_pending_i,
    input  logic          last_in_block_i,
    output logic [W-1:0]  word_o,
    output logic          suffix_placed_o
);

    localparam int unsigned NB = W / 8;

    always_comb begin
        suffix_placed_o = suffix_pending_i && (count_i < CW'(NB));
        word_o = '0;
        for (int i = 0; i < NB; i++) begin
            if (CW'(i) < count_i) begin
                word_o[8*i +: 8] = word_i[8*i +: 8];
            end else if (CW'(i) == count_i && suffix_pending_i) begin
                word_o[8*i +: 8] = suffix_i;
            end
        end
        // The pad bit may only close a block once the suffix precedes it.
        if (last_in_block_i && (!suffix_pending_i || suffix_placed_o)) begin
            word_o[W-1 -: 8] = word_o[W-1 -: 8] | PAD_END;
        end
    end

endmodule

// File: rtl/keccak_load_stage.sv
// Keccak input stage: parses the header, absorbs message words, pads and
// hands rate-sized blocks to the absorb stage.
module keccak_load_stage
    import keccak_pkg::*;
#(
    parameter int unsigned W        = 64,
    parameter int unsigned RATE_MAX = 1344
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [W-1:0]        data_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [RATE_MAX-1:0] block_o,
    output logic                block_valid_o,
    input  logic                block_ready_i,
    output logic                last_block_o,
    output logic [2:0]          mode_o,
    output logic [31:0]         output_size_o,
    output logic                busy_o
);

    localparam int unsigned NB  = W / 8;
    localparam int unsigned CW  = $clog2(NB + 1);
    localparam int unsigned NW  = RATE_MAX / W;
    localparam int unsigned WCW = $clog2(RATE_MAX / 32);

    typedef enum logic [2:0] {StIdle, StHeader, StAbsorb, StPad, StHold} state_e;

    state_e              state_q, state_d;
    logic                run_q;
    logic [RATE_MAX-1:0] block_q, block_d;
    logic [WCW-1:0]      wc_q, wc_d;
    logic [28:0]         bytes_left_q, bytes_left_d;
    logic                suffix_done_q, suffix_done_d;
    logic                last_q, last_d;
    mode_t               mode_q, mode_d;
    logic [27:0]         out_size_q, out_size_d;

    logic [31:0]   hdr_hi, hdr_lo;
    logic [63:0]   swap64;
    logic [W-1:0]  padded;
    logic [CW-1:0] pad_cnt;
    logic          suffix_placed, last_in_block, accept, wr_en;
    logic [7:0]    suffix;
    logic          unused_bits;

    assign hdr_hi = data_i[W-1 -: 32];
    assign hdr_lo = data_i[31:0];
    // Left-justify so that message byte 0 lands in bits [7:0] after the swap.
    assign swap64 = EndianSwitcher(64'(data_i) << (64 - W));
    assign unused_bits = ^{hdr_hi[28], hdr_lo[2:0], swap64};

    assign pad_cnt = (state_q != StAbsorb)        ? '0 :
                     (bytes_left_q >= 29'(NB))    ? CW'(NB) : CW'(bytes_left_q);
    assign last_in_block = (wc_q == WCW'(rate_bits(mode_q) / W - 1));
    assign suffix = is_shake(mode_q) ? SUFFIX_SHAKE : SUFFIX_SHA3;

    assign ready_o = run_q &&
                     (state_q == StIdle || state_q == StHeader || state_q == StAbsorb);
    assign accept  = valid_i && ready_o;

    keccak_word_padder #(
        .W  (W),
        .CW (CW)
    ) u_padder (
        .word_i           (swap64[W-1:0]),
        .count_i          (pad_cnt),
        .suffix_i         (suffix),
        .suffix_pending_i (!suffix_done_q),
        .last_in_block_i  (last_in_block),
        .word_o           (padded),
        .suffix_placed_o  (suffix_placed)
    );

    always_comb begin
        state_d       = state_q;
        block_d       = block_q;
        wc_d          = wc_q;
        bytes_left_d  = bytes_left_q;
        suffix_done_d = suffix_done_q;
        last_d        = last_q;
        mode_d        = mode_q;
        out_size_d    = out_size_q;
        wr_en         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    mode_d        = mode_decode(hdr_hi[31:29]);
                    out_size_d    = hdr_hi[27:0];
                    suffix_done_d = 1'b0;
                    last_d        = 1'b0;
                    wc_d          = '0;
                    block_d       = '0;
                    if (W == 32) begin
                        state_d = StHeader;
                    end else begin
                        bytes_left_d = hdr_lo[31:3];
                        state_d      = (hdr_lo[31:3] == '0) ? StPad : StAbsorb;
                    end
                end
            end
            StHeader: begin
                if (accept) begin
                    bytes_left_d = hdr_lo[31:3];
                    state_d      = (hdr_lo[31:3] == '0) ? StPad : StAbsorb;
                end
            end
            StAbsorb: wr_en = accept;
            StPad:    wr_en = 1'b1;
            StHold: begin
                if (block_ready_i) begin
                    block_d = '0;
                    wc_d    = '0;
                    last_d  = 1'b0;
                    if (last_q)                  state_d = StIdle;
                    else if (bytes_left_q != '0) state_d = StAbsorb;
                    else                         state_d = StPad;
                end
            end
            default: state_d = StIdle;
        endcase

        if (wr_en) begin
            for (int i = 0; i < NW; i++) begin
                if (wc_q == WCW'(i)) block_d[i*W +: W] = padded;
            end
            wc_d          = wc_q + 1'b1;
            bytes_left_d  = bytes_left_q - 29'(pad_cnt);
            suffix_done_d = suffix_done_q | suffix_placed;
            last_d        = last_in_block && (suffix_done_q || suffix_placed);
            if (last_in_block)            state_d = StHold;
            else if (bytes_left_d == '0)  state_d = StPad;
            else                          state_d = StAbsorb;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            run_q         <= 1'b0;
            block_q       <= '0;
            wc_q          <= '0;
            bytes_left_q  <= '0;
            suffix_done_q <= 1'b0;
            last_q        <= 1'b0;
            mode_q        <= Sha3_224;
            out_size_q    <= '0;
        end else begin
            state_q       <= state_d;
            run_q         <= 1'b1;
            block_q       <= block_d;
            wc_q          <= wc_d;
            bytes_left_q  <= bytes_left_d;
            suffix_done_q <= suffix_done_d;
            last_q        <= last_d;
            mode_q        <= mode_d;
            out_size_q    <= out_size_d;
        end
    end

    assign block_o       = block_q;
    assign block_valid_o = (state_q == StHold);
    assign last_block_o  = last_q;
    assign mode_o        = mode_q;
    assign output_size_o = {4'b0, out_size_q};
    assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_keccak_load_stage.sv
// Directed bench for keccak_load_stage with 64-bit and 32-bit bus instances.
module tb_keccak_load_stage;

    localparam int RM = 1344;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [63:0]   d64 = '0;
    logic          v64 = 1'b0, br64 = 1'b0;
    logic          rdy64, bv64, lb64, busy64;
    logic [RM-1:0] blk64;
    logic [2:0]    mode64;
    logic [31:0]   osz64;

    logic [31:0]   d32 = '0;
    logic          v32 = 1'b0, br32 = 1'b0;
    logic          rdy32, bv32, lb32, busy32;
    logic [RM-1:0] blk32;
    logic [2:0]    mode32;
    logic [31:0]   osz32;

    int vectors = 0;
    int fails = 0;
    logic [7:0]    msg [0:255];
    logic [RM-1:0] exp_blk;

    keccak_load_stage #(.W(64), .RATE_MAX(RM)) dut64 (
        .clk(clk), .rst(rst), .data_i(d64), .valid_i(v64), .ready_o(rdy64),
        .block_o(blk64), .block_valid_o(bv64), .block_ready_i(br64),
        .last_block_o(lb64), .mode_o(mode64), .output_size_o(osz64), .busy_o(busy64)
    );

    keccak_load_stage #(.W(32), .RATE_MAX(RM)) dut32 (
        .clk(clk), .rst(rst), .data_i(d32), .valid_i(v32), .ready_o(rdy32),
        .block_o(blk32), .block_valid_o(bv32), .block_ready_i(br32),
        .last_block_o(lb32), .mode_o(mode32), .output_size_o(osz32), .busy_o(busy32)
    );

    function automatic logic [63:0] msg_word(input int base);
        logic [63:0] w = '0;
        for (int i = 0; i < 8; i++) w = (w << 8) | 64'(msg[base + i]);
        return w;
    endfunction

    task automatic send64(input logic [63:0] w, input bit gaps);
        int n = 0;
        if (gaps && $urandom_range(0, 1) == 1) begin
            v64 = 1'b0;
            @(negedge clk);
        end
        d64 = w;
        v64 = 1'b1;
        while (!rdy64 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            $display("FAIL send64 timeout: ready_o=%b required 1", rdy64);
            fails++; vectors++;
        end
        @(negedge clk);
        v64 = 1'b0;
    endtask

    task automatic send32(input logic [31:0] w);
        int n = 0;
        d32 = w;
        v32 = 1'b1;
        while (!rdy32 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            $display("FAIL send32 timeout: ready_o=%b required 1", rdy32);
            fails++; vectors++;
        end
        @(negedge clk);
        v32 = 1'b0;
    endtask

    task automatic wait_bv64(input string name);
        int n = 0;
        while (!bv64 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            $display("FAIL %s block_valid timeout: got %b required 1", name, bv64);
            fails++; vectors++;
        end
    endtask

    task automatic wait_bv32(input string name);
        int n = 0;
        while (!bv32 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            $display("FAIL %s block_valid timeout: got %b required 1", name, bv32);
            fails++; vectors++;
        end
    endtask

    task automatic release64();
        br64 = 1'b1;
        @(negedge clk);
        br64 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++; if (rdy64 !== 1'b0) begin $display("FAIL rst_ready64 got %b req 0", rdy64); fails++; end
        vectors++; if (rdy32 !== 1'b0) begin $display("FAIL rst_ready32 got %b req 0", rdy32); fails++; end
        vectors++; if (blk64 !== '0) begin $display("FAIL rst_block got %h req 0", blk64); fails++; end
        vectors++; if ({bv64, lb64, busy64} !== 3'b000) begin
            $display("FAIL rst_flags got %b req 000", {bv64, lb64, busy64}); fails++; end
        vectors++; if ({mode64, osz64} !== 35'd0) begin
            $display("FAIL rst_mode_size got %h req 0", {mode64, osz64}); fails++; end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (rdy64 !== 1'b1) begin $display("FAIL idle_ready64 got %b req 1", rdy64); fails++; end
        vectors++; if (rdy32 !== 1'b1) begin $display("FAIL idle_ready32 got %b req 1", rdy32); fails++; end
    endtask

    task automatic test_shake128_empty();
        send64({3'd4, 1'b0, 28'd256, 32'd0}, 1'b0);
        wait_bv64("shake128_empty");
        exp_blk = '0;
        exp_blk[7:0] = 8'h1F;
        exp_blk[167*8 +: 8] = 8'h80;
        vectors++; if (blk64 !== exp_blk) begin
            $display("FAIL empty_block got %h req %h", blk64, exp_blk); fails++; end
        vectors++; if (lb64 !== 1'b1) begin $display("FAIL empty_last got %b req 1", lb64); fails++; end
        vectors++; if (mode64 !== 3'd4) begin $display("FAIL empty_mode got %0d req 4", mode64); fails++; end
        vectors++; if (osz64 !== 32'd256) begin $display("FAIL empty_osize got %0d req 256", osz64); fails++; end
        release64();
        vectors++; if ({busy64, bv64} !== 2'b00) begin
            $display("FAIL empty_done got %b req 00", {busy64, bv64}); fails++; end
    endtask

    task automatic test_sha3_256_135();
        for (int k = 0; k < 256; k++) msg[k] = 8'(k * 7 + 3);
        send64({3'd1, 1'b0, 28'd256, 32'd1080}, 1'b0);
        for (int j = 0; j < 17; j++) send64(msg_word(8 * j), 1'b0);
        wait_bv64("sha3_256_135");
        exp_blk = '0;
        for (int k = 0; k < 135; k++) exp_blk[8*k +: 8] = msg[k];
        exp_blk[135*8 +: 8] = 8'h86;
        vectors++; if (blk64 !== exp_blk) begin
            $display("FAIL s256_block got %h req %h", blk64, exp_blk); fails++; end
        vectors++; if (lb64 !== 1'b1) begin $display("FAIL s256_last got %b req 1", lb64); fails++; end
        release64();
        repeat (3) @(negedge clk);
        vectors++; if ({busy64, bv64} !== 2'b00) begin
            $display("FAIL s256_no_extra got %b req 00", {busy64, bv64}); fails++; end
    endtask

    task automatic test_sha3_512_full_rate();
        for (int k = 0; k < 256; k++) msg[k] = 8'(255 - k * 5);
        send64({3'd3, 1'b0, 28'd512, 32'd576}, 1'b0);
        for (int j = 0; j < 9; j++) send64(msg_word(8 * j), 1'b1);
        wait_bv64("s512_blk1");
        exp_blk = '0;
        for (int k = 0; k < 72; k++) exp_blk[8*k +: 8] = msg[k];
        vectors++; if (blk64 !== exp_blk) begin
            $display("FAIL s512_blk1 got %h req %h", blk64, exp_blk); fails++; end
        vectors++; if (lb64 !== 1'b0) begin $display("FAIL s512_last1 got %b req 0", lb64); fails++; end
        release64();
        wait_bv64("s512_blk2");
        exp_blk = '0;
        exp_blk[7:0] = 8'h06;
        exp_blk[71*8 +: 8] = 8'h80;
        vectors++; if (blk64 !== exp_blk) begin
            $display("FAIL s512_blk2 got %h req %h", blk64, exp_blk); fails++; end
        vectors++; if (lb64 !== 1'b1) begin $display("FAIL s512_last2 got %b req 1", lb64); fails++; end
        release64();
    endtask

    task automatic test_w32_shake256();
        send32(32'hA000_0200);
        send32(32'd24);
        send32(32'hAABB_CCDD);
        wait_bv32("w32_shake256");
        exp_blk = '0;
        exp_blk[31:0] = 32'h1FCC_BBAA;
        exp_blk[135*8 +: 8] = 8'h80;
        vectors++; if (blk32 !== exp_blk) begin
            $display("FAIL w32_block got %h req %h", blk32, exp_blk); fails++; end
        vectors++; if (lb32 !== 1'b1) begin $display("FAIL w32_last got %b req 1", lb32); fails++; end
        vectors++; if (mode32 !== 3'd5) begin $display("FAIL w32_mode got %0d req 5", mode32); fails++; end
        vectors++; if (osz32 !== 32'd512) begin $display("FAIL w32_osize got %0d req 512", osz32); fails++; end
        br32 = 1'b1;
        @(negedge clk);
        br32 = 1'b0;
        vectors++; if (busy32 !== 1'b0) begin $display("FAIL w32_done got %b req 0", busy32); fails++; end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 256; k++) msg[k] = 8'(k * 13 + 9);
        send64({3'd0, 1'b0, 28'd224, 32'd1600}, 1'b0);
        for (int j = 0; j < 18; j++) send64(msg_word(8 * j), 1'b1);
        wait_bv64("bp_blk1");
        exp_blk = '0;
        for (int k = 0; k < 144; k++) exp_blk[8*k +: 8] = msg[k];
        d64 = msg_word(144);
        v64 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            vectors++; if (rdy64 !== 1'b0) begin
                $display("FAIL bp_ready cycle %0d got %b req 0", c, rdy64); fails++; end
            vectors++; if (bv64 !== 1'b1) begin
                $display("FAIL bp_valid cycle %0d got %b req 1", c, bv64); fails++; end
            vectors++; if (blk64 !== exp_blk) begin
                $display("FAIL bp_stable cycle %0d got %h req %h", c, blk64, exp_blk); fails++; end
            @(negedge clk);
        end
        vectors++; if (lb64 !== 1'b0) begin $display("FAIL bp_last1 got %b req 0", lb64); fails++; end
        release64();
        for (int j = 18; j < 25; j++) send64(msg_word(8 * j), j != 18);
        wait_bv64("bp_blk2");
        exp_blk = '0;
        for (int k = 0; k < 56; k++) exp_blk[8*k +: 8] = msg[144 + k];
        exp_blk[56*8 +: 8] = 8'h06;
        exp_blk[143*8 +: 8] = 8'h80;
        vectors++; if (blk64 !== exp_blk) begin
            $display("FAIL bp_blk2 got %h req %h", blk64, exp_blk); fails++; end
        vectors++; if (lb64 !== 1'b1) begin $display("FAIL bp_last2 got %b req 1", lb64); fails++; end
        release64();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 256; k++) msg[k] = 8'(k + 1);
        send64({3'd1, 1'b0, 28'd256, 32'd1080}, 1'b0);
        for (int j = 0; j < 5; j++) send64(msg_word(8 * j), 1'b0);
        rst = 1'b0;
        #1;
        vectors++; if (blk64 !== '0) begin $display("FAIL mid_rst_block got %h req 0", blk64); fails++; end
        vectors++; if ({rdy64, bv64, lb64, busy64} !== 4'b0000) begin
            $display("FAIL mid_rst_flags got %b req 0000", {rdy64, bv64, lb64, busy64}); fails++; end
        vectors++; if ({mode64, osz64} !== 35'd0) begin
            $display("FAIL mid_rst_mode_size got %h req 0", {mode64, osz64}); fails++; end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        msg[0] = 8'h12;
        msg[1] = 8'h34;
        for (int k = 2; k < 8; k++) msg[k] = 8'hFF;
        send64({3'd2, 1'b0, 28'd384, 32'd16}, 1'b0);
        send64(msg_word(0), 1'b0);
        wait_bv64("post_rst");
        exp_blk = '0;
        exp_blk[23:0] = 24'h06_3412;
        exp_blk[103*8 +: 8] = 8'h80;
        vectors++; if (blk64 !== exp_blk) begin
            $display("FAIL post_rst_block got %h req %h", blk64, exp_blk); fails++; end
        vectors++; if ({lb64, mode64} !== 4'b1_010) begin
            $display("FAIL post_rst_last_mode got %b req 1010", {lb64, mode64}); fails++; end
        vectors++; if (osz64 !== 32'd384) begin
            $display("FAIL post_rst_osize got %0d req 384", osz64); fails++; end
        release64();
    endtask

    initial begin
        test_reset();
        test_shake128_empty();
        test_sha3_256_135();
        test_sha3_512_full_rate();
        test_w32_shake256();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
